request_encoder8to3: RTL and testbench



---
 rtl/request_encoder8to3_if.sv | 31 +++
 rtl/request_encoder8to3.sv | 102 ++++++++++
 tb/tb_request_encoder8to3.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/request_encoder8to3_if.sv
// Request/offer bundle between event sources, the encoder and its consumer.
// slave is the encoder side; master is the source/consumer side.
interface request_encoder8to3_if;
  logic [7:0] req;
  logic       ready;
  logic       valid;
  logic [2:0] addr;
  logic [7:0] grant;
  logic [7:0] pending;
  logic       lost;

  modport slave (
    input  req,
    input  ready,
    output valid,
    output addr,
    output grant,
    output pending,
    output lost
  );

  modport master (
    output req,
    output ready,
    input  valid,
    input  addr,
    input  grant,
    input  pending,
    input  lost
  );
endinterface

// File: rtl/request_encoder8to3.sv
// Collects 8 request strobes into a pending register and offers them
// round-robin as a 3-bit address over a valid/ready handshake.
module request_encoder8to3 (
  input  logic                    clock,
  input  logic                    resetn,
  request_encoder8to3_if.slave    bus
);

  localparam int unsigned NREQ = 8;
  localparam int unsigned AW   = 3;

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_OFFER = 1'b1;

  logic [0:0]      state_q, state_d;
  logic            valid_q, valid_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] pending_q, pending_d;
  logic            lost_q, lost_d;

  logic            acc;
  logic [NREQ-1:0] clr;

  // First set bit of p scanning upward from start, wrapping modulo 8.
  function automatic logic [AW-1:0] sel_fn(input logic [NREQ-1:0] p,
                                           input logic [AW-1:0]   start);
    logic [AW-1:0] idx;
    logic          found;
    sel_fn = start;
    found  = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      idx = start + AW'(i);
      if (!found && p[idx]) begin
        sel_fn = idx;
        found  = 1'b1;
      end
    end
  endfunction

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      valid_q   <= 1'b0;
      addr_q    <= '0;
      ptr_q     <= '0;
      pending_q <= '0;
      lost_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      addr_q    <= addr_d;
      ptr_q     <= ptr_d;
      pending_q <= pending_d;
      lost_q    <= lost_d;
    end
  end

  // A same-cycle request on the bit being cleared wins and re-arms it.
  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    addr_d    = addr_q;
    acc       = (state_q == ST_OFFER) && bus.ready;
    clr       = acc ? (NREQ'(1) << addr_q) : '0;
    pending_d = (pending_q & ~clr) | bus.req;
    ptr_d     = acc ? (addr_q + AW'(1)) : ptr_q;
    lost_d    = |(bus.req & pending_q & ~clr);

    case (state_q)
      ST_IDLE: begin
        if (pending_d != '0) begin
          state_d = ST_OFFER;
          valid_d = 1'b1;
          addr_d  = sel_fn(pending_d, ptr_d);
        end
      end
      ST_OFFER: begin
        // Offer stays frozen until the consumer takes it.
        if (bus.ready) begin
          if (pending_d != '0) begin
            addr_d = sel_fn(pending_d, ptr_d);
          end else begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  assign bus.valid   = valid_q;
  assign bus.addr    = addr_q;
  assign bus.grant   = valid_q ? (NREQ'(1) << addr_q) : '0;
  assign bus.pending = pending_q;
  assign bus.lost    = lost_q;

endmodule

// File: tb/tb_request_encoder8to3.sv
// Directed bench for request_encoder8to3: reset, round-robin order,
// offer stability, duplicate requests and asynchronous reset.
module tb_request_encoder8to3;

  logic clock;
  logic resetn;
  int   total;
  int   bad;

  request_encoder8to3_if bus ();

  request_encoder8to3 dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    bus.req   = 8'h00;
    bus.ready = 1'b0;
    resetn    = 1'b0;
    step();
    resetn = 1'b1;
    step();
  endtask

  task automatic test_reset();
    bus.req   = 8'hFF;
    bus.ready = 1'b1;
    resetn    = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0h exp=0", bus.valid); end
      total++; if (bus.addr !== 3'd0) begin bad++; $display("FAIL reset_addr got=%0h exp=0", bus.addr); end
      total++; if (bus.grant !== 8'h00) begin bad++; $display("FAIL reset_grant got=%0h exp=0", bus.grant); end
      total++; if (bus.pending !== 8'h00) begin bad++; $display("FAIL reset_pending got=%0h exp=0", bus.pending); end
      total++; if (bus.lost !== 1'b0) begin bad++; $display("FAIL reset_lost got=%0h exp=0", bus.lost); end
    end
    bus.req = 8'h00;
    resetn  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL post_reset_valid got=%0h exp=0", bus.valid); end
      total++; if (bus.pending !== 8'h00) begin bad++; $display("FAIL post_reset_pending got=%0h exp=0", bus.pending); end
    end
  endtask

  task automatic test_single();
    do_reset();
    bus.ready = 1'b1;
    bus.req   = 8'h04;
    step();
    bus.req = 8'h00;
    total++; if (bus.valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%0h exp=1", bus.valid); end
    total++; if (bus.addr !== 3'd2) begin bad++; $display("FAIL single_addr got=%0h exp=2", bus.addr); end
    total++; if (bus.grant !== 8'h04) begin bad++; $display("FAIL single_grant got=%0h exp=04", bus.grant); end
    step();
    total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL single_drain_valid got=%0h exp=0", bus.valid); end
    total++; if (bus.pending !== 8'h00) begin bad++; $display("FAIL single_drain_pending got=%0h exp=0", bus.pending); end
    total++; if (bus.grant !== 8'h00) begin bad++; $display("FAIL single_drain_grant got=%0h exp=0", bus.grant); end
    // ptr is now 3: bits 0 and 3 pending must yield 3 first, then wrap to 0.
    bus.req = 8'h09;
    step();
    bus.req = 8'h00;
    total++; if (bus.addr !== 3'd3) begin bad++; $display("FAIL single_ptr_first got=%0h exp=3", bus.addr); end
    step();
    total++; if (bus.addr !== 3'd0 || bus.valid !== 1'b1) begin bad++; $display("FAIL single_ptr_wrap got=%0h/%0h exp=0/1", bus.addr, bus.valid); end
    step();
    total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL single_ptr_idle got=%0h exp=0", bus.valid); end
  endtask

  task automatic test_sweep();
    do_reset();
    bus.ready = 1'b1;
    for (int r = 0; r < 2; r++) begin
      bus.req = 8'hFF;
      step();
      bus.req = 8'h00;
      for (int k = 0; k < 8; k++) begin
        if (k != 0) step();
        total++;
        if (bus.valid !== 1'b1 || bus.addr !== 3'(k)) begin
          bad++; $display("FAIL sweep%0d_addr%0d got=%0h/%0h exp=1/%0h", r, k, bus.valid, bus.addr, k);
        end
      end
      step();
      total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL sweep%0d_end got=%0h exp=0", r, bus.valid); end
    end
  endtask

  task automatic test_stability();
    do_reset();
    bus.ready = 1'b0;
    bus.req   = 8'h20;
    step();
    total++; if (bus.addr !== 3'd5 || bus.valid !== 1'b1) begin bad++; $display("FAIL stab_offer got=%0h/%0h exp=5/1", bus.addr, bus.valid); end
    bus.req = 8'h01;
    for (int i = 0; i < 3; i++) begin
      step();
      bus.req = 8'h00;
      total++; if (bus.addr !== 3'd5 || bus.valid !== 1'b1) begin bad++; $display("FAIL stab_hold%0d got=%0h/%0h exp=5/1", i, bus.addr, bus.valid); end
    end
    total++; if (bus.pending !== 8'h21) begin bad++; $display("FAIL stab_pending got=%0h exp=21", bus.pending); end
    bus.ready = 1'b1;
    step();
    total++; if (bus.addr !== 3'd0 || bus.valid !== 1'b1) begin bad++; $display("FAIL stab_next got=%0h/%0h exp=0/1", bus.addr, bus.valid); end
    step();
    total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL stab_idle got=%0h exp=0", bus.valid); end
  endtask

  task automatic test_duplicate();
    do_reset();
    bus.ready = 1'b0;
    bus.req   = 8'h08;
    step();
    total++; if (bus.addr !== 3'd3 || bus.lost !== 1'b0) begin bad++; $display("FAIL dup_offer got=%0h/%0h exp=3/0", bus.addr, bus.lost); end
    step();
    bus.req = 8'h00;
    total++; if (bus.lost !== 1'b1) begin bad++; $display("FAIL dup_lost got=%0h exp=1", bus.lost); end
    total++; if (bus.pending !== 8'h08) begin bad++; $display("FAIL dup_pending got=%0h exp=08", bus.pending); end
    step();
    total++; if (bus.lost !== 1'b0) begin bad++; $display("FAIL dup_lost_pulse got=%0h exp=0", bus.lost); end
    bus.ready = 1'b1;
    bus.req   = 8'h08;
    step();
    bus.req = 8'h00;
    total++; if (bus.lost !== 1'b0) begin bad++; $display("FAIL simul_lost got=%0h exp=0", bus.lost); end
    total++; if (bus.pending !== 8'h08) begin bad++; $display("FAIL simul_pending got=%0h exp=08", bus.pending); end
    total++; if (bus.addr !== 3'd3 || bus.valid !== 1'b1) begin bad++; $display("FAIL simul_offer got=%0h/%0h exp=3/1", bus.addr, bus.valid); end
    step();
    total++; if (bus.valid !== 1'b0 || bus.pending !== 8'h00) begin bad++; $display("FAIL simul_drain got=%0h/%0h exp=0/00", bus.valid, bus.pending); end
  endtask

  task automatic test_async_reset();
    do_reset();
    bus.ready = 1'b0;
    bus.req   = 8'hC0;
    step();
    bus.req = 8'h00;
    total++; if (bus.addr !== 3'd6 || bus.pending !== 8'hC0) begin bad++; $display("FAIL arst_setup got=%0h/%0h exp=6/c0", bus.addr, bus.pending); end
    #2;
    resetn = 1'b0;
    #1;
    total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%0h exp=0", bus.valid); end
    total++; if (bus.addr !== 3'd0) begin bad++; $display("FAIL arst_addr got=%0h exp=0", bus.addr); end
    total++; if (bus.grant !== 8'h00) begin bad++; $display("FAIL arst_grant got=%0h exp=0", bus.grant); end
    total++; if (bus.pending !== 8'h00) begin bad++; $display("FAIL arst_pending got=%0h exp=0", bus.pending); end
    step();
    #2;
    resetn    = 1'b1;
    bus.ready = 1'b1;
    step();
    step();
    total++; if (bus.valid !== 1'b0) begin bad++; $display("FAIL arst_idle got=%0h exp=0", bus.valid); end
    bus.req = 8'h02;
    step();
    bus.req = 8'h00;
    total++; if (bus.addr !== 3'd1 || bus.valid !== 1'b1) begin bad++; $display("FAIL arst_resume got=%0h/%0h exp=1/1", bus.addr, bus.valid); end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    resetn    = 1'b0;
    bus.req   = 8'h00;
    bus.ready = 1'b0;
    test_reset();
    test_single();
    test_sweep();
    test_stability();
    test_duplicate();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
